video_colour_mode_pipe: RTL and testbench

//  Parametrised, pipelined colour-mode stage between the core's RGB/sync outputs and the
//  VGA scandoubler. Replaces the combinational monochrome mapping: adds luminance-based

---
 rtl/video_colour_mode_pipe.sv | 152 +++++++++++++++
 tb/tb_video_colour_mode_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_colour_mode_pipe.sv
// Two-stage colour-mode pipeline between the core RGB/sync outputs and the scandoubler.
// Luminance-based grey/green/amber modes, blanking override, and mode switching on frame edges.
module video_colour_mode_pipe #(
    parameter int CW            = 3,
    parameter bit SYNC_ON_VSYNC = 1'b1
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          pixel_en,
    input  logic [2:0]    mode_req,
    input  logic          blank,
    input  logic [CW-1:0] ri,
    input  logic [CW-1:0] gi,
    input  logic [CW-1:0] bi,
    input  logic          hsync_n_i,
    input  logic          vsync_n_i,
    input  logic          csync_n_i,
    output logic [CW-1:0] ro,
    output logic [CW-1:0] go,
    output logic [CW-1:0] bo,
    output logic          hsync_n_o,
    output logic          vsync_n_o,
    output logic          csync_n_o,
    output logic [2:0]    mode_act
);

    localparam int YW = CW + 4;

    localparam logic [2:0] MODE_COLOUR = 3'd0;
    localparam logic [2:0] MODE_GREY   = 3'd1;
    localparam logic [2:0] MODE_GREEN  = 3'd2;
    localparam logic [2:0] MODE_AMBER  = 3'd3;

    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return (m > MODE_AMBER) ? MODE_COLOUR : m;
    endfunction

    // Weights sum to 16, so all-ones inputs give exactly 16*max and fit in CW+4 bits.
    function automatic logic [YW-1:0] luma_sum(input logic [CW-1:0] r,
                                               input logic [CW-1:0] g,
                                               input logic [CW-1:0] b);
        logic [YW-1:0] rr, gg, bb;
        rr = YW'(r);
        gg = YW'(g);
        bb = YW'(b);
        return rr * YW'(5) + gg * YW'(9) + bb * YW'(2);
    endfunction

    function automatic logic [CW-1:0] luma_round(input logic [YW-1:0] s);
        return CW'((s + YW'(8)) >> 4);
    endfunction

    logic [CW-1:0] r_p1, g_p1, b_p1;
    logic [YW-1:0] ysum_p1;
    logic          blank_p1, hs_p1, vs_p1, cs_p1;
    logic [2:0]    mode_p1;
    logic          vs_prev, vs_armed, frame_edge;
    logic [CW-1:0] y, r_map, g_map, b_map;

    // Edge needs a high sample since reset, so vsync held low through reset is ignored.
    assign frame_edge = pixel_en && !vsync_n_i && vs_prev && vs_armed;

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            mode_act <= MODE_COLOUR;
            vs_prev  <= 1'b1;
            vs_armed <= 1'b0;
        end else if (pixel_en) begin
            vs_prev <= vsync_n_i;
            if (vsync_n_i)
                vs_armed <= 1'b1;
            if (!SYNC_ON_VSYNC || frame_edge)
                mode_act <= norm_mode(mode_req);
        end
    end

    // Stage 1: luminance sum, pixel, blank, syncs and the mode in force for this pixel
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_p1     <= '0;
            g_p1     <= '0;
            b_p1     <= '0;
            ysum_p1  <= '0;
            blank_p1 <= 1'b0;
            hs_p1    <= 1'b1;
            vs_p1    <= 1'b1;
            cs_p1    <= 1'b1;
            mode_p1  <= MODE_COLOUR;
        end else if (pixel_en) begin
            r_p1     <= ri;
            g_p1     <= gi;
            b_p1     <= bi;
            ysum_p1  <= luma_sum(ri, gi, bi);
            blank_p1 <= blank;
            hs_p1    <= hsync_n_i;
            vs_p1    <= vsync_n_i;
            cs_p1    <= csync_n_i;
            mode_p1  <= mode_act;
        end
    end

    assign y = luma_round(ysum_p1);

    always_comb begin
        r_map = r_p1;
        g_map = g_p1;
        b_map = b_p1;
        case (mode_p1)
            MODE_GREY: begin
                r_map = y;
                g_map = y;
                b_map = y;
            end
            MODE_GREEN: begin
                r_map = '0;
                g_map = y;
                b_map = '0;
            end
            MODE_AMBER: begin
                r_map = y;
                g_map = y - (y >> 2);
                b_map = '0;
            end
            default: ;
        endcase
        if (blank_p1) begin
            r_map = '0;
            g_map = '0;
            b_map = '0;
        end
    end

    // Stage 2: mapped colour and delayed syncs
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            ro        <= '0;
            go        <= '0;
            bo        <= '0;
            hsync_n_o <= 1'b1;
            vsync_n_o <= 1'b1;
            csync_n_o <= 1'b1;
        end else if (pixel_en) begin
            ro        <= r_map;
            go        <= g_map;
            bo        <= b_map;
            hsync_n_o <= hs_p1;
            vsync_n_o <= vs_p1;
            csync_n_o <= cs_p1;
        end
    end

endmodule

// File: tb/tb_video_colour_mode_pipe.sv
// Bench for video_colour_mode_pipe: CW=3/frame-synced and CW=8/free-running instances share
// one stimulus stream; a queue-based reference model checks every cycle, plus directed vectors.
module tb_video_colour_mode_pipe;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       hs, vs, cs;
    } pix_t;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] r, g, b;
        logic       blank;
        logic [7:0] e3r, e3g, e3b, e8r, e8g, e8b;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, pixel_en, blank, hs_i, vs_i, cs_i;
    logic [2:0] mode_req;
    logic [7:0] ri, gi, bi;

    logic [2:0] ro3, go3, bo3, mode3;
    logic [7:0] ro8, go8, bo8;
    logic [2:0] mode8;
    logic       hs3, vs3, cs3, hs8, vs8, cs8;

    int checks = 0;
    int errors = 0;

    pix_t q3[$], q8[$];
    pix_t out3, out8;
    int   m_mode3, m_mode8;
    logic m_last_vs, m_seen_high;

    always #5 clk = ~clk;

    video_colour_mode_pipe #(.CW(3), .SYNC_ON_VSYNC(1'b1)) dut3 (
        .sysclk(clk), .rst_n(rst_n), .pixel_en(pixel_en), .mode_req(mode_req), .blank(blank),
        .ri(ri[2:0]), .gi(gi[2:0]), .bi(bi[2:0]),
        .hsync_n_i(hs_i), .vsync_n_i(vs_i), .csync_n_i(cs_i),
        .ro(ro3), .go(go3), .bo(bo3),
        .hsync_n_o(hs3), .vsync_n_o(vs3), .csync_n_o(cs3), .mode_act(mode3)
    );

    video_colour_mode_pipe #(.CW(8), .SYNC_ON_VSYNC(1'b0)) dut8 (
        .sysclk(clk), .rst_n(rst_n), .pixel_en(pixel_en), .mode_req(mode_req), .blank(blank),
        .ri(ri), .gi(gi), .bi(bi),
        .hsync_n_i(hs_i), .vsync_n_i(vs_i), .csync_n_i(cs_i),
        .ro(ro8), .go(go8), .bo(bo8),
        .hsync_n_o(hs8), .vsync_n_o(vs8), .csync_n_o(cs8), .mode_act(mode8)
    );

    function automatic int norm(input int m);
        return (m > 3) ? 0 : m;
    endfunction

    // Expected output pixel straight from the colour-mode rules, in integer arithmetic.
    function automatic pix_t expect_pix(input int cw, input int mode, input int r_in,
                                        input int g_in, input int b_in, input logic blk);
        pix_t p;
        int mask, r, g, b, y;
        mask = (1 << cw) - 1;
        r = r_in & mask;
        g = g_in & mask;
        b = b_in & mask;
        y = (5 * r + 9 * g + 2 * b + 8) / 16;
        case (mode)
            1: begin p.r = 8'(y); p.g = 8'(y); p.b = 8'(y); end
            2: begin p.r = 0; p.g = 8'(y); p.b = 0; end
            3: begin p.r = 8'(y); p.g = 8'(y - y / 4); p.b = 0; end
            default: begin p.r = 8'(r); p.g = 8'(g); p.b = 8'(b); end
        endcase
        if (blk) begin
            p.r = 0; p.g = 0; p.b = 0;
        end
        p.hs = hs_i;
        p.vs = vs_i;
        p.cs = cs_i;
        return p;
    endfunction

    task automatic model_reset();
        pix_t idle;
        idle = '{r: 8'd0, g: 8'd0, b: 8'd0, hs: 1'b1, vs: 1'b1, cs: 1'b1};
        q3.delete();
        q8.delete();
        q3.push_back(idle);
        q8.push_back(idle);
        out3 = idle;
        out8 = idle;
        m_mode3 = 0;
        m_mode8 = 0;
        m_last_vs = 1'b1;
        m_seen_high = 1'b0;
    endtask

    task automatic model_strobe();
        q3.push_back(expect_pix(3, m_mode3, int'(ri), int'(gi), int'(bi), blank));
        q8.push_back(expect_pix(8, m_mode8, int'(ri), int'(gi), int'(bi), blank));
        out3 = q3.pop_front();
        out8 = q8.pop_front();
        if (!vs_i && m_last_vs && m_seen_high)
            m_mode3 = norm(int'(mode_req));
        m_last_vs = vs_i;
        if (vs_i)
            m_seen_high = 1'b1;
        m_mode8 = norm(int'(mode_req));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m3_r", 32'(ro3), 32'(out3.r));
        chk("m3_g", 32'(go3), 32'(out3.g));
        chk("m3_b", 32'(bo3), 32'(out3.b));
        chk("m3_hs", 32'(hs3), 32'(out3.hs));
        chk("m3_vs", 32'(vs3), 32'(out3.vs));
        chk("m3_cs", 32'(cs3), 32'(out3.cs));
        chk("m3_mode", 32'(mode3), 32'(m_mode3));
        chk("m8_r", 32'(ro8), 32'(out8.r));
        chk("m8_g", 32'(go8), 32'(out8.g));
        chk("m8_b", 32'(bo8), 32'(out8.b));
        chk("m8_hs", 32'(hs8), 32'(out8.hs));
        chk("m8_vs", 32'(vs8), 32'(out8.vs));
        chk("m8_cs", 32'(cs8), 32'(out8.cs));
        chk("m8_mode", 32'(mode8), 32'(m_mode8));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n)
            model_reset();
        else if (pixel_en)
            model_strobe();
        #1;
        check_model();
    endtask

    task automatic set_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        ri = r;
        gi = g;
        bi = b;
    endtask

    // Produce a vsync falling edge so the frame-synced instance latches mode_req.
    task automatic frame_edge_with(input logic [2:0] m);
        mode_req = m;
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
        vs_i = 1'b1;
        tick();
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{3'd1, 8'd255, 8'd255, 8'd255, 1'b0, 8'd7, 8'd7, 8'd7, 8'd255, 8'd255, 8'd255};
        vt[1] = '{3'd1, 8'd255, 8'd0,   8'd0,   1'b0, 8'd2, 8'd2, 8'd2, 8'd80,  8'd80,  8'd80};
        vt[2] = '{3'd1, 8'd0,   8'd255, 8'd0,   1'b0, 8'd4, 8'd4, 8'd4, 8'd143, 8'd143, 8'd143};
        vt[3] = '{3'd3, 8'd0,   8'd255, 8'd0,   1'b0, 8'd4, 8'd3, 8'd0, 8'd143, 8'd108, 8'd0};
        vt[4] = '{3'd2, 8'd255, 8'd255, 8'd255, 1'b0, 8'd0, 8'd7, 8'd0, 8'd0,   8'd255, 8'd0};
        vt[5] = '{3'd0, 8'd7,   8'd3,   8'd1,   1'b0, 8'd7, 8'd3, 8'd1, 8'd7,   8'd3,   8'd1};
        vt[6] = '{3'd3, 8'd255, 8'd255, 8'd255, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0,   8'd0,   8'd0};

        // Reset with random inputs
        rst_n = 1'b0;
        pixel_en = 1'b1;
        mode_req = 3'($urandom);
        blank = 1'b0;
        set_rgb(8'($urandom), 8'($urandom), 8'($urandom));
        hs_i = 1'b0; vs_i = 1'b0; cs_i = 1'b0;
        tick();
        tick();
        chk("rst_ro", 32'(ro3), 0);
        chk("rst_go", 32'(go3), 0);
        chk("rst_bo", 32'(bo3), 0);
        chk("rst_hs", 32'(hs3), 1);
        chk("rst_vs", 32'(vs3), 1);
        chk("rst_cs", 32'(cs3), 1);
        chk("rst_mode", 32'(mode3), 0);
        chk("rst_ro8", 32'(ro8), 0);

        // vsync held low across reset release must not count as an edge
        rst_n = 1'b1;
        mode_req = 3'd2;
        blank = 1'b1;
        hs_i = 1'b1; cs_i = 1'b1;
        repeat (3) tick();
        chk("vs_low_rel_mode", 32'(mode3), 0);
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
        chk("vs_first_edge_mode", 32'(mode3), 2);
        vs_i = 1'b1;
        tick();

        // Directed vectors: mode set on a frame edge, one pixel, read one strobe later
        foreach (vt[i]) begin
            blank = 1'b1;
            frame_edge_with(vt[i].mode);
            chk("vec_mode", 32'(mode3), 32'(vt[i].mode));
            set_rgb(vt[i].r, vt[i].g, vt[i].b);
            blank = vt[i].blank;
            hs_i = 1'b0;
            tick();
            set_rgb(8'd0, 8'd0, 8'd0);
            blank = 1'b0;
            hs_i = 1'b1;
            tick();
            chk("vec3_r", 32'(ro3), 32'(vt[i].e3r));
            chk("vec3_g", 32'(go3), 32'(vt[i].e3g));
            chk("vec3_b", 32'(bo3), 32'(vt[i].e3b));
            chk("vec8_r", 32'(ro8), 32'(vt[i].e8r));
            chk("vec8_g", 32'(go8), 32'(vt[i].e8g));
            chk("vec8_b", 32'(bo8), 32'(vt[i].e8b));
            chk("vec_hs_aligned", 32'(hs3), 0);
        end

        // Latency with pixel_en on every second cycle, hsync aligned with the pixel
        blank = 1'b0;
        frame_edge_with(3'd0);
        pixel_en = 1'b0;
        tick();
        pixel_en = 1'b1;
        set_rgb(8'd7, 8'd3, 8'd1);
        hs_i = 1'b0;
        tick();
        pixel_en = 1'b0;
        set_rgb(8'd0, 8'd0, 8'd0);
        hs_i = 1'b1;
        tick();
        chk("lat_not_yet_hs", 32'(hs3), 1);
        pixel_en = 1'b1;
        tick();
        chk("lat_r", 32'(ro3), 7);
        chk("lat_g", 32'(go3), 3);
        chk("lat_b", 32'(bo3), 1);
        chk("lat_hs", 32'(hs3), 0);
        pixel_en = 1'b0;
        tick();
        chk("lat_hold_r", 32'(ro3), 7);
        pixel_en = 1'b1;

        // Mid-frame mode request is deferred to the next vsync edge
        mode_req = 3'd1;
        set_rgb(8'd255, 8'd0, 8'd0);
        repeat (3) tick();
        chk("fs_deferred3", 32'(mode3), 0);
        chk("fs_immediate8", 32'(mode8), 1);
        vs_i = 1'b0;
        tick();
        chk("fs_applied", 32'(mode3), 1);
        tick();
        chk("fs_edge_pix_r", 32'(ro3), 7);
        chk("fs_edge_pix_g", 32'(go3), 0);
        tick();
        chk("fs_first_grey_r", 32'(ro3), 2);
        chk("fs_first_grey_g", 32'(go3), 2);
        mode_req = 3'd6;
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
        chk("fs_mode6_3", 32'(mode3), 0);
        chk("fs_mode6_8", 32'(mode8), 0);
        vs_i = 1'b1;
        tick();

        // Blank in amber keeps syncs delayed; then hold outputs with pixel_en low
        frame_edge_with(3'd3);
        set_rgb(8'd255, 8'd255, 8'd255);
        blank = 1'b1;
        hs_i = 1'b0;
        cs_i = 1'b0;
        tick();
        blank = 1'b0;
        hs_i = 1'b1;
        cs_i = 1'b1;
        tick();
        chk("blank_r", 32'(ro3), 0);
        chk("blank_g", 32'(go3), 0);
        chk("blank_hs", 32'(hs3), 0);
        chk("blank_cs", 32'(cs3), 0);
        tick();
        pixel_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_rgb(8'($urandom), 8'($urandom), 8'($urandom));
            mode_req = 3'($urandom);
            vs_i = 1'($urandom);
            hs_i = 1'($urandom);
            tick();
            chk("hold_r", 32'(ro3), 7);
            chk("hold_g", 32'(go3), 6);
        end
        pixel_en = 1'b1;
        vs_i = 1'b1;
        hs_i = 1'b1;

        // Reset mid-pipeline while amber is active
        chk("pre_rst_mode", 32'(mode3), 3);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_r", 32'(ro3), 0);
        chk("mid_rst_hs", 32'(hs3), 1);
        chk("mid_rst_mode", 32'(mode3), 0);
        rst_n = 1'b1;

        // Randomised run against the reference model
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            pixel_en = ($urandom_range(0, 2) != 0);
            mode_req = 3'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            set_rgb(8'($urandom), 8'($urandom), 8'($urandom));
            hs_i = ($urandom_range(0, 9) != 0);
            vs_i = ($urandom_range(0, 24) != 0);
            cs_i = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
